regfile_ctrl: RTL and testbench

- Initiator-side controller for the 16x32 `registers` block (two read ports, one write port).
- Accepts operand-fetch requests from decode over a valid/ready handshake and sequences `re`/`rs1`/`rs2` into the register file.
- Captures the read data and returns both operands over a valid/ready handshake.
- Drives the write port from writeback, keeps a busy scoreboard for RAW/WAW stalls, and forwards same-window writes into operands.

---
 rtl/regfile_ctrl_if.sv | 44 ++++
 rtl/regfile_ctrl.sv | 131 +++++++++++++
 tb/tb_regfile_ctrl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/regfile_ctrl_if.sv
// Signal bundle between regfile_ctrl and its neighbours: decode issue, operand return,
// writeback, and the 16x32 register-file ports.
interface regfile_ctrl_if #(
    parameter int AW = 4,
    parameter int DW = 32
);
    logic                 iss_valid;
    logic                 iss_ready;
    logic [AW-1:0]        iss_rs1;
    logic [AW-1:0]        iss_rs2;
    logic [AW-1:0]        iss_rd;
    logic                 iss_wen;
    logic                 op_valid;
    logic                 op_ready;
    logic [DW-1:0]        op_a;
    logic [DW-1:0]        op_b;
    logic [AW-1:0]        op_rd;
    logic                 wb_valid;
    logic [AW-1:0]        wb_rd;
    logic [DW-1:0]        wb_data;
    logic                 we;
    logic [AW-1:0]        rd;
    logic [DW-1:0]        write_data;
    logic                 re;
    logic [AW-1:0]        rs1;
    logic [AW-1:0]        rs2;
    logic [DW-1:0]        read_data_1;
    logic [DW-1:0]        read_data_2;
    logic [(2**AW)-1:0]   busy;

    modport slave (
        input  iss_valid, iss_rs1, iss_rs2, iss_rd, iss_wen, op_ready,
               wb_valid, wb_rd, wb_data, read_data_1, read_data_2,
        output iss_ready, op_valid, op_a, op_b, op_rd,
               we, rd, write_data, re, rs1, rs2, busy
    );

    modport master (
        output iss_valid, iss_rs1, iss_rs2, iss_rd, iss_wen, op_ready,
               wb_valid, wb_rd, wb_data, read_data_1, read_data_2,
        input  iss_ready, op_valid, op_a, op_b, op_rd,
               we, rd, write_data, re, rs1, rs2, busy
    );
endinterface

// File: rtl/regfile_ctrl.sv
// Operand-fetch controller for the 16x32 register file: issue handshake, read sequencing,
// busy scoreboard for RAW/WAW stalls, and forwarding of writes landing in the read window.
//
// state   | meaning
// S_IDLE  | ready for a new request (unless the scoreboard stalls it)
// S_RD    | re asserted with the latched source addresses
// S_WAIT  | read data returning; operands captured at end of cycle
// S_VALID | operands presented until the consumer takes them
module regfile_ctrl #(
    parameter int AW = 4,
    parameter int DW = 32
) (
    input  logic           clk,
    input  logic           reset,
    regfile_ctrl_if.slave  bus
);
    localparam int NR = 2**AW;

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WAIT, S_VALID} state_t;

    state_t         state_q;
    logic [NR-1:0]  busy_q, busy_d;
    logic [AW-1:0]  rs1_q, rs2_q, rd_q, op_rd_q;
    logic           re_q, op_valid_q, fwd1_q, fwd2_q;
    logic [DW-1:0]  op_a_q, op_b_q, fwd1_data_q, fwd2_data_q;
    logic           we, stall, accept, hit1, hit2;
    logic [DW-1:0]  cap_a, cap_b;

    assign we             = reset && bus.wb_valid && (bus.wb_rd != '0);
    assign bus.we         = we;
    assign bus.rd         = reset ? bus.wb_rd : '0;
    assign bus.write_data = reset ? bus.wb_data : '0;

    // Stall is judged on the registered scoreboard, so a same-cycle writeback releases it one cycle later.
    assign stall = busy_q[bus.iss_rs1] | busy_q[bus.iss_rs2] | (bus.iss_wen & busy_q[bus.iss_rd]);
    assign bus.iss_ready = (state_q == S_IDLE) && !stall;
    assign accept        = bus.iss_valid && bus.iss_ready;

    assign hit1 = we && (bus.wb_rd == rs1_q);
    assign hit2 = we && (bus.wb_rd == rs2_q);

    assign bus.re       = re_q;
    assign bus.rs1      = rs1_q;
    assign bus.rs2      = rs2_q;
    assign bus.op_valid = op_valid_q;
    assign bus.op_a     = op_a_q;
    assign bus.op_b     = op_b_q;
    assign bus.op_rd    = op_rd_q;
    assign bus.busy     = busy_q;

    always_comb begin
        cap_a = fwd1_q ? fwd1_data_q : bus.read_data_1;
        cap_b = fwd2_q ? fwd2_data_q : bus.read_data_2;
        if (hit1)
            cap_a = bus.wb_data;
        if (hit2)
            cap_b = bus.wb_data;
        if (rs1_q == '0)
            cap_a = '0;
        if (rs2_q == '0)
            cap_b = '0;

        // Clear before set: a new reservation outranks a retiring write to the same register.
        busy_d = busy_q;
        if (we)
            busy_d[bus.wb_rd] = 1'b0;
        if (accept && bus.iss_wen && (bus.iss_rd != '0))
            busy_d[bus.iss_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            busy_q      <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            re_q        <= 1'b0;
            fwd1_q      <= 1'b0;
            fwd2_q      <= 1'b0;
            fwd1_data_q <= '0;
            fwd2_data_q <= '0;
            op_valid_q  <= 1'b0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_rd_q     <= '0;
        end else begin
            busy_q <= busy_d;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        rs1_q   <= bus.iss_rs1;
                        rs2_q   <= bus.iss_rs2;
                        rd_q    <= bus.iss_rd;
                        fwd1_q  <= 1'b0;
                        fwd2_q  <= 1'b0;
                        re_q    <= 1'b1;
                        state_q <= S_RD;
                    end
                end
                S_RD: begin
                    re_q <= 1'b0;
                    if (hit1) begin
                        fwd1_q      <= 1'b1;
                        fwd1_data_q <= bus.wb_data;
                    end
                    if (hit2) begin
                        fwd2_q      <= 1'b1;
                        fwd2_data_q <= bus.wb_data;
                    end
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    op_a_q     <= cap_a;
                    op_b_q     <= cap_b;
                    op_rd_q    <= rd_q;
                    op_valid_q <= 1'b1;
                    state_q    <= S_VALID;
                end
                S_VALID: begin
                    if (bus.op_ready) begin
                        op_valid_q <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_ctrl.sv
// Bench for regfile_ctrl: directed scenarios then random traffic, checked every cycle
// against a transaction-level model of the architectural registers and scoreboard.
module tb_regfile_ctrl;
    logic clk;
    logic reset;

    regfile_ctrl_if #(.AW(4), .DW(32)) bus ();

    regfile_ctrl #(.AW(4), .DW(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Register-file stand-in: registered read, write at the clock edge.
    logic [31:0] mem [16];
    logic [31:0] rd1_q, rd2_q;
    always_ff @(posedge clk) begin
        if (bus.re) begin
            rd1_q <= mem[bus.rs1];
            rd2_q <= mem[bus.rs2];
        end
        if (bus.we)
            mem[bus.rd] <= bus.write_data;
    end
    assign bus.read_data_1 = rd1_q;
    assign bus.read_data_2 = rd2_q;

    int n_chk  = 0;
    int n_pass = 0;

    // Model: architectural values, pending writes, and the single outstanding request.
    logic [31:0] arch [16];
    bit          m_busy [16];
    bit          pend;
    int          age;
    logic [3:0]  p_rs1, p_rs2, p_rd;
    logic [31:0] exp_a, exp_b;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic step(input logic v, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] d, input logic w, input logic wv,
                        input logic [3:0] wr, input logic [31:0] wd,
                        input logic ordy, input logic rstn);
        logic        m_ready;
        logic [15:0] bvec;
        reset         = rstn;
        bus.iss_valid = v;
        bus.iss_rs1   = a;
        bus.iss_rs2   = b;
        bus.iss_rd    = d;
        bus.iss_wen   = w;
        bus.wb_valid  = wv;
        bus.wb_rd     = wr;
        bus.wb_data   = wd;
        bus.op_ready  = ordy;
        #1;
        for (int i = 0; i < 16; i++)
            bvec[i] = m_busy[i];
        m_ready = !pend && !(m_busy[a] || m_busy[b] || (w && m_busy[d]));
        chk("iss_ready", bus.iss_ready, m_ready);
        chk("op_valid", bus.op_valid, pend && age == 3);
        chk("re", bus.re, pend && age == 1);
        chk("we", bus.we, rstn && wv && wr != 0);
        chk("busy", bus.busy, bvec);
        if (rstn && wv && wr != 0) begin
            chk("rd", bus.rd, wr);
            chk("write_data", bus.write_data, wd);
        end
        if (pend && (age == 1 || age == 2)) begin
            chk("rs1", bus.rs1, p_rs1);
            chk("rs2", bus.rs2, p_rs2);
        end
        if (pend && age == 3) begin
            chk("op_a", bus.op_a, exp_a);
            chk("op_b", bus.op_b, exp_b);
            chk("op_rd", bus.op_rd, p_rd);
        end
        @(posedge clk);
        if (!rstn) begin
            pend = 0;
            for (int i = 0; i < 16; i++)
                m_busy[i] = 0;
        end else begin
            if (wv && wr != 0) begin
                arch[wr]   = wd;
                m_busy[wr] = 0;
            end
            // Operands are the newest architectural values as of the capture edge.
            if (pend && age == 2) begin
                exp_a = (p_rs1 == 0) ? 32'h0 : arch[p_rs1];
                exp_b = (p_rs2 == 0) ? 32'h0 : arch[p_rs2];
                age   = 3;
            end else if (pend && age == 3) begin
                if (ordy)
                    pend = 0;
            end else if (pend && age == 1) begin
                age = 2;
            end else if (!pend && v && m_ready) begin
                pend  = 1;
                age   = 1;
                p_rs1 = a;
                p_rs2 = b;
                p_rd  = d;
                if (w && d != 0)
                    m_busy[d] = 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int i = 0; i < n; i++)
            step(0, 0, 0, 0, 0, 0, 0, 0, ordy, 1);
    endtask

    task automatic req(input logic [3:0] a, input logic [3:0] b, input logic [3:0] d, input logic w);
        step(1, a, b, d, w, 0, 0, 0, 1, 1);
    endtask

    task automatic wb(input logic [3:0] r, input logic [31:0] dat);
        step(0, 0, 0, 0, 0, 1, r, dat, 1, 1);
    endtask

    initial begin
        logic [3:0] wr;
        int         start;
        clk = 0;
        pend = 0;
        age = 0;
        for (int i = 0; i < 16; i++) begin
            arch[i]   = 32'h0;
            m_busy[i] = 0;
        end
        reset = 0;
        bus.iss_valid = 0; bus.iss_rs1 = 0; bus.iss_rs2 = 0; bus.iss_rd = 0; bus.iss_wen = 0;
        bus.wb_valid = 0; bus.wb_rd = 0; bus.wb_data = 0; bus.op_ready = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_op_a", bus.op_a, 32'h0);
        chk("rst_op_b", bus.op_b, 32'h0);
        chk("rst_op_rd", bus.op_rd, 4'h0);
        chk("rst_rs1", bus.rs1, 4'h0);
        chk("rst_rs2", bus.rs2, 4'h0);

        for (int i = 1; i < 16; i++)
            wb(4'(i), 32'(i));

        req(2, 3, 0, 0);
        idle(4, 1);

        req(5, 6, 7, 1);
        idle(4, 1);
        repeat (3) req(7, 1, 0, 0);
        step(1, 7, 1, 0, 0, 1, 7, 32'hAA, 1, 1);
        req(7, 1, 0, 0);
        idle(4, 1);

        req(4, 4, 0, 0);
        wb(4, 32'h1234);
        idle(3, 1);
        req(4, 4, 0, 0);
        idle(1, 1);
        wb(4, 32'h5678);
        idle(2, 1);
        req(4, 4, 0, 0);
        wb(4, 32'h1111);
        wb(4, 32'h2222);
        idle(2, 1);

        wb(0, 32'h9999_9999);
        req(0, 2, 0, 0);
        idle(4, 1);
        req(1, 2, 0, 1);
        idle(4, 1);

        req(3, 5, 0, 0);
        idle(2, 0);
        for (int i = 0; i < 5; i++)
            step(1, 1, 1, 0, 0, 0, 0, 0, 0, 1);
        idle(3, 1);

        req(8, 8, 9, 1);
        idle(1, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        req(9, 10, 11, 1);
        idle(4, 1);
        wb(11, 32'hBEEF);

        for (int n = 0; n < 1500; n++) begin
            wr = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                start = $urandom_range(0, 15);
                for (int k = 0; k < 16; k++)
                    if (m_busy[(start + k) % 16]) wr = 4'((start + k) % 16);
            end
            step($urandom_range(0, 3) != 0,
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 2) == 0, wr, $urandom,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 99) != 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
